instruction_fetch: RTL and testbench

Fetch stage sitting directly upstream of the decode stage. It owns the program counter and issues fetch requests to instruction memory over a req/ack handshake. It holds the fetched word in the IF/ID pipeline register (Instr, PC, PC+4, valid) that drives decode. It takes branch/jump redirects, hazard stalls and flushes from later stages, and absorbs a fetch that completes while decode is stalled.

---
 rtl/instruction_fetch.sv | 130 +++++++++++++
 tb/tb_instruction_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, talks to instruction memory over req/ack,
// and drives the IF/ID register with a one-entry skid for stalled fetches.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        valid
);

    typedef enum logic [1:0] {
        START = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } skid_t;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    skid_t       skid_q, skid_d;

    logic        ack;
    logic [31:0] pc_inc;

    assign imem_req  = (state_q == REQ);
    assign imem_addr = {pc_q[31:2], 2'b00};
    assign ack       = imem_req & imem_ack;
    assign pc_inc    = imem_addr + 32'd4;

    assign Instr   = ifid_q.instr;
    assign PC      = ifid_q.pc;
    assign PCPlus4 = ifid_q.pc4;
    assign valid   = ifid_q.valid;

    // Next state: redirect beats flush beats stall beats normal fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        skid_d  = skid_q;

        if (pc_src) begin
            pc_d    = {pc_target[31:2], 2'b00};
            state_d = REQ;
            if (flush) begin
                ifid_d.instr = NOP_INSTR;
                ifid_d.valid = 1'b0;
            end
        end else if (flush) begin
            // Any acked word is dropped and the PC stays put for a refetch.
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
            state_d      = REQ;
        end else begin
            unique case (state_q)
                START: state_d = REQ;
                REQ: begin
                    if (ack) begin
                        pc_d = pc_inc;
                        if (stall) begin
                            skid_d.instr = imem_rdata;
                            skid_d.pc    = imem_addr;
                            skid_d.pc4   = pc_inc;
                            state_d      = HOLD;
                        end else begin
                            ifid_d.instr = imem_rdata;
                            ifid_d.pc    = imem_addr;
                            ifid_d.pc4   = pc_inc;
                            ifid_d.valid = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_d.instr = skid_q.instr;
                        ifid_d.pc    = skid_q.pc;
                        ifid_d.pc4   = skid_q.pc4;
                        ifid_d.valid = 1'b1;
                        state_d      = REQ;
                    end
                end
                default: state_d = START;
            endcase
        end
    end

    // State, PC, skid and IF/ID registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= START;
            pc_q         <= RESET_PC;
            skid_q       <= '0;
            ifid_q.instr <= NOP_INSTR;
            ifid_q.pc    <= 32'd0;
            ifid_q.pc4   <= 32'd0;
            ifid_q.valid <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
            ifid_q  <= ifid_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random traffic,
// all checked against a queue-based model of the fetch rules.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        valid;

    int n_checks;
    int n_errors;

    // Reference model state
    bit          m_start;
    logic [31:0] m_pc;
    logic [63:0] m_skid[$];
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic        m_v;

    instruction_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .pc_src    (pc_src),
        .pc_target (pc_target),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .Instr     (Instr),
        .PC        (PC),
        .PCPlus4   (PCPlus4),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_start = 1'b1;
        m_pc    = 32'd0;
        m_skid.delete();
        m_instr = NOP;
        m_ipc   = 32'd0;
        m_ipc4  = 32'd0;
        m_v     = 1'b0;
    endtask

    function automatic bit m_req();
        return !m_start && (m_skid.size() == 0);
    endfunction

    task automatic check_all(input string ph);
        check({ph, ".req"},   {31'd0, imem_req}, {31'd0, m_req()});
        check({ph, ".addr"},  imem_addr, m_pc);
        check({ph, ".instr"}, Instr, m_instr);
        check({ph, ".pc"},    PC, m_ipc);
        check({ph, ".pc4"},   PCPlus4, m_ipc4);
        check({ph, ".valid"}, {31'd0, valid}, {31'd0, m_v});
    endtask

    task automatic model_edge(input bit st, input bit fl, input bit ps,
                              input logic [31:0] tg, input bit ak);
        bit          got;
        logic [63:0] e;
        got = m_req() && ak;
        if (ps || fl) begin
            if (ps) m_pc = tg & 32'hFFFF_FFFC;
            if (fl) begin
                m_instr = NOP;
                m_v     = 1'b0;
            end
            m_skid.delete();
            m_start = 1'b0;
        end else if (m_start) begin
            m_start = 1'b0;
        end else if (m_skid.size() != 0) begin
            if (!st) begin
                e       = m_skid.pop_front();
                m_instr = e[63:32];
                m_ipc   = e[31:0];
                m_ipc4  = e[31:0] + 32'd4;
                m_v     = 1'b1;
            end
        end else if (got) begin
            if (st) begin
                m_skid.push_back({mem(m_pc), m_pc});
            end else begin
                m_instr = mem(m_pc);
                m_ipc   = m_pc;
                m_ipc4  = m_pc + 32'd4;
                m_v     = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input string ph, input bit st, input bit fl,
                        input bit ps, input logic [31:0] tg, input bit ak);
        check_all(ph);
        stall      = st;
        flush      = fl;
        pc_src     = ps;
        pc_target  = tg;
        imem_ack   = ak;
        imem_rdata = ak ? mem(m_pc) : $urandom;
        @(posedge clk);
        model_edge(st, fl, ps, tg, ak);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        stall    = 1'b0;
        flush    = 1'b0;
        pc_src   = 1'b0;
        imem_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_all("rst");
        end
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        pc_src     = 1'b0;
        pc_target  = 32'd0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        model_reset();
        @(negedge clk);

        do_reset();
        for (int i = 0; i < 5; i++) step("start", 0, 0, 0, 0, 1);

        do_reset();
        for (int i = 0; i < 10; i++) step("wait", 0, 0, 0, 0, (i % 3) == 2);

        do_reset();
        step("stl", 0, 0, 0, 0, 1);
        step("stl", 0, 0, 0, 0, 1);
        step("stl", 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step("stl", 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("stl", 0, 0, 0, 0, 1);

        step("redir", 0, 1, 1, 32'h0000_0103, 1);
        for (int i = 0; i < 3; i++) step("redir", 0, 0, 0, 0, 1);

        step("flst", 1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("flst", 0, 0, 0, 0, 1);

        step("wrap", 0, 0, 1, 32'hFFFF_FFFC, 0);
        for (int i = 0; i < 3; i++) step("wrap", 0, 0, 0, 0, 1);
        step("wrap", 1, 0, 0, 0, 1);
        step("wrap", 1, 0, 0, 0, 1);

        check_all("hold");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        @(negedge clk);
        check_all("arst");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step("arst", 0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tg;
            tg = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            step("rnd",
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0,
                 tg,
                 $urandom_range(0, 9) < 6);
        end
        check_all("end");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
